// File: rtl/jk_count_pkg.sv
// Shared types for jk_count_seq: controller state encoding and JK cell control codes.
// Latency: none (declarations only).
// Backpressure: none.
package jk_count_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // {j,k} codes applied to one JK cell
   localparam logic [1:0] HOLD   = 2'b00;
   localparam logic [1:0] RESET  = 2'b01;
   localparam logic [1:0] SET    = 2'b10;
   localparam logic [1:0] TOGGLE = 2'b11;

   // Code that forces a cell to the given bit value on the next edge
   function automatic logic [1:0] jk_load(input logic b);
      return b ? SET : RESET;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop with synchronous active-high clear.
// Latency: q reflects j/k one clock after they are sampled.
// Backpressure: none; the cell acts every clock edge.
module jk_cell (
   input  logic clock,
   input  logic clear,
   input  logic j,
   input  logic k,
   output logic q
);

   // Classic JK behaviour: 00 hold, 01 reset, 10 set, 11 toggle
   always_ff @(posedge clock) begin
      if (clear) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_count_seq.sv
// Modulo-MOD pass counter built from WIDTH JK cells, sequenced by an IDLE/RUN/DONE FSM.
// Latency: start to first count 1 clock; a pass is MOD RUN cycles then one DONE cycle.
// Backpressure: none; start is only honoured in IDLE, stop only in RUN (macro JK_COUNT_DOWN_EN adds down counting).
module jk_count_seq
   import jk_count_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             stop,
   input  logic             dir,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] TERM = WIDTH'(MOD - 1);

   state_t           state, state_next;
   logic [1:0]       jk [WIDTH];
   logic [WIDTH-1:0] up_en;
   logic [WIDTH-1:0] step_en;
   logic [WIDTH-1:0] start_load;
   logic [WIDTH-1:0] term_load;
   logic             at_term;

   // Bit i toggles on an up step once every lower bit is 1
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_up_en
      if (gi == 0) begin : g_lsb
         assign up_en[gi] = 1'b1;
      end else begin : g_upper
         assign up_en[gi] = &count[gi-1:0];
      end
   end

`ifdef JK_COUNT_DOWN_EN
   logic             dir_q;
   logic [WIDTH-1:0] dn_en;

   // Bit i toggles on a down step once every lower bit is 0
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dn_en
      if (gi == 0) begin : g_lsb
         assign dn_en[gi] = 1'b1;
      end else begin : g_upper
         assign dn_en[gi] = ~|count[gi-1:0];
      end
   end

   // Direction is latched with the accepted start and held for the pass
   always_ff @(posedge clock) begin
      if (clear) begin
         dir_q <= 1'b0;
      end else if (state == IDLE && start) begin
         dir_q <= dir;
      end
   end

   assign step_en    = dir_q ? dn_en : up_en;
   assign at_term    = dir_q ? (count == '0) : (count == TERM);
   assign start_load = dir ? TERM : '0;
   assign term_load  = dir_q ? TERM : '0;
`else
   // Up-only build: dir is accepted on the port but has no effect
   logic unused_dir;
   assign unused_dir = dir;

   assign step_en    = up_en;
   assign at_term    = (count == TERM);
   assign start_load = '0;
   assign term_load  = '0;
`endif

   // Counter storage: the controller only ever drives J/K, never count itself
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      jk_cell u_cell (
         .clock (clock),
         .clear (clear),
         .j     (jk[gi][1]),
         .k     (jk[gi][0]),
         .q     (count[gi])
      );
   end

   // State register; clear wins over every other event
   always_ff @(posedge clock) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and per-cell J/K codes; stop outranks the terminal count
   always_comb begin
      state_next = state;
      for (int i = 0; i < WIDTH; i++) jk[i] = HOLD;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               for (int i = 0; i < WIDTH; i++) jk[i] = jk_load(start_load[i]);
            end
         end
         RUN: begin
            if (stop) begin
               state_next = IDLE;
            end else if (at_term) begin
               state_next = DONE;
               for (int i = 0; i < WIDTH; i++) jk[i] = jk_load(term_load[i]);
            end else begin
               for (int i = 0; i < WIDTH; i++) jk[i] = step_en[i] ? TOGGLE : HOLD;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_jk_count_seq.sv
// Directed bench for jk_count_seq at WIDTH=4, MOD=10.
// Inputs are driven and outputs sampled 1 time unit after each rising clock edge.
// Expected down-count behaviour follows whether JK_COUNT_DOWN_EN is defined.
module tb_jk_count_seq;

   localparam int WIDTH = 4;
   localparam int MOD   = 10;
`ifdef JK_COUNT_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             clear = 1'b1;
   logic             start = 1'b0;
   logic             stop  = 1'b0;
   logic             dir   = 1'b0;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;

   int checks   = 0;
   int failures = 0;

   jk_count_seq #(.WIDTH(WIDTH), .MOD(MOD)) dut (
      .clock (clock),
      .clear (clear),
      .start (start),
      .stop  (stop),
      .dir   (dir),
      .count (count),
      .busy  (busy),
      .done  (done)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_out(input string tag, input int c, input int b, input int d);
      check({tag, "_count"}, int'(count), c);
      check({tag, "_busy"},  int'(busy),  b);
      check({tag, "_done"},  int'(done),  d);
   endtask

   // One full pass; d=1 requests down counting (only effective with the macro)
   task automatic run_pass(input string tag, input logic d);
      bit down;
      int exp_c;
      down  = DOWN_EN && d;
      dir   = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      dir   = 1'b0;
      for (int i = 0; i < MOD; i++) begin
         exp_c = down ? (MOD - 1 - i) : i;
         check_out({tag, "_run"}, exp_c, 1, 0);
         tick();
      end
      exp_c = down ? (MOD - 1) : 0;
      check_out({tag, "_done"}, exp_c, 0, 1);
      tick();
      check_out({tag, "_idle"}, exp_c, 0, 0);
   endtask

   initial begin
      // Reset and idle hold
      tick();
      tick();
      clear = 1'b0;
      check_out("reset", 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
         check_out("idle_hold", 0, 0, 0);
      end

      // Full up pass
      run_pass("up", 1'b0);

      // Stop at 4: count holds, no done
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_out("pre_stop4", 4, 1, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_out("stop4", 4, 0, 0);
      repeat (3) begin
         tick();
         check_out("stop4_idle", 4, 0, 0);
      end

      // Stop outside RUN is ignored; start in RUN is not a restart
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_out("stop_idle_ign", 4, 0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check_out("restart", 0, 1, 0);
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      check_out("start_in_run", 4, 1, 0);

      // Clear mid-pass at 6: abort, no done
      tick();
      tick();
      check_out("pre_clear6", 6, 1, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_out("clear6", 0, 0, 0);
      tick();
      check_out("clear6_idle", 0, 0, 0);
      run_pass("after_clear", 1'b0);

      // Stop coincident with terminal count
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      check_out("pre_stop9", 9, 1, 0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_out("stop9", 9, 0, 0);
      tick();
      check_out("stop9_idle", 9, 0, 0);

      // Down request (counts up when the macro is absent)
      run_pass("dir1", 1'b1);
      run_pass("up_again", 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
